// File: rtl/tecmo_input_pkg.sv
// Shared constants for the arcade player-input front end: PS/2 keymap,
// joystick word bit positions and width helpers.
package tecmo_input_pkg;

  localparam int unsigned JOY_RIGHT = 0;
  localparam int unsigned JOY_LEFT  = 1;
  localparam int unsigned JOY_DOWN  = 2;
  localparam int unsigned JOY_UP    = 3;
  localparam int unsigned JOY_BTN0  = 4;

  localparam logic [7:0] KEY_P1_UP    = 8'h75;
  localparam logic [7:0] KEY_P1_DOWN  = 8'h72;
  localparam logic [7:0] KEY_P1_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_P1_RIGHT = 8'h74;
  localparam logic [7:0] KEY_P1_BTN0  = 8'h14;
  localparam logic [7:0] KEY_P1_BTN1  = 8'h11;
  localparam logic [7:0] KEY_P1_BTN2  = 8'h29;
  localparam logic [7:0] KEY_P1_START = 8'h16;
  localparam logic [7:0] KEY_P1_COIN  = 8'h2E;
  localparam logic [7:0] KEY_P1_PAUSE = 8'h4D;

  localparam logic [7:0] KEY_P2_UP    = 8'h2D;
  localparam logic [7:0] KEY_P2_DOWN  = 8'h2B;
  localparam logic [7:0] KEY_P2_LEFT  = 8'h23;
  localparam logic [7:0] KEY_P2_RIGHT = 8'h34;
  localparam logic [7:0] KEY_P2_BTN0  = 8'h1C;
  localparam logic [7:0] KEY_P2_BTN1  = 8'h1B;
  localparam logic [7:0] KEY_P2_BTN2  = 8'h15;
  localparam logic [7:0] KEY_P2_START = 8'h1E;
  localparam logic [7:0] KEY_P2_COIN  = 8'h36;

  // Joystick word: 4 directions, nb buttons, start, coin, pause.
  function automatic int unsigned joy_width(input int unsigned nb);
    return nb + 7;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tecmo_input_pulse.sv
// Rising-edge triggered one-shot: pulse is high for exactly CYCLES clocks,
// starting one clock after the trigger edge; edges during a pulse are ignored.
module tecmo_input_pulse
  import tecmo_input_pkg::*;
#(
  parameter int unsigned CYCLES = 9600000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic trig,
  output logic pulse
);

  localparam int unsigned CW = cnt_width(CYCLES);

  logic          trig_q;
  logic [CW-1:0] cnt_q;

  // Counter holds remaining cycles minus one so CYCLES fits in $clog2 bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_q <= 1'b0;
      cnt_q  <= '0;
      pulse  <= 1'b0;
    end else begin
      trig_q <= trig;
      if (pulse) begin
        if (cnt_q == '0) pulse <= 1'b0;
        else             cnt_q <= cnt_q - CW'(1);
      end else if (trig && !trig_q) begin
        pulse <= 1'b1;
        cnt_q <= CW'(CYCLES - 1);
      end
    end
  end

endmodule

// File: rtl/tecmo_input.sv
// Player-input front end: PS/2 key decode merged with HPS joystick words,
// SOCD cleaning, shared-phase autofire, coin one-shots and a pause toggle.
module tecmo_input
  import tecmo_input_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS  = 2,
  parameter int unsigned NUM_BUTTONS  = 3,
  parameter int unsigned AUTOFIRE_DIV = 1600000,
  parameter int unsigned COIN_CYCLES  = 9600000
) (
  input  logic                                                  clk,
  input  logic                                                  reset_n,
  input  logic [10:0]                                           ps2_key,
  input  logic [NUM_PLAYERS-1:0][joy_width(NUM_BUTTONS)-1:0]    joystick,
  input  logic                                                  socd_clean,
  input  logic [NUM_PLAYERS-1:0][NUM_BUTTONS-1:0]               autofire_en,
  output logic [NUM_PLAYERS-1:0][3:0]                           joy,
  output logic [NUM_PLAYERS-1:0][NUM_BUTTONS-1:0]               buttons,
  output logic [NUM_PLAYERS-1:0]                                start,
  output logic [NUM_PLAYERS-1:0]                                coin,
  output logic                                                  pause
);

  localparam int unsigned JW       = joy_width(NUM_BUTTONS);
  localparam int unsigned AFW      = cnt_width(AUTOFIRE_DIV);
  localparam int unsigned JOY_STRT = JOY_BTN0 + NUM_BUTTONS;
  localparam int unsigned JOY_COIN = JOY_BTN0 + NUM_BUTTONS + 1;
  localparam int unsigned JOY_PAUS = JOY_BTN0 + NUM_BUTTONS + 2;

  logic                 strobe_q;
  logic [1:0][JW-1:0]   key_q;
  logic [1:0][JW-1:0]   key_hit;
  logic [AFW-1:0]       af_cnt_q;
  logic                 phase_q;
  logic                 pause_prev_q;
  logic                 unused;

  logic [NUM_PLAYERS-1:0][3:0]             joy_d;
  logic [NUM_PLAYERS-1:0][NUM_BUTTONS-1:0] btn_d;
  logic [NUM_PLAYERS-1:0]                  start_d;
  logic [NUM_PLAYERS-1:0]                  raw_coin;
  logic [NUM_PLAYERS-1:0]                  raw_pause;
  logic                                    pause_any;

  assign unused = ps2_key[8];

  // Scancode to key-register bit, laid out like the joystick word.
  always_comb begin
    key_hit = '0;
    case (ps2_key[7:0])
      KEY_P1_UP:    key_hit[0][JOY_UP]    = 1'b1;
      KEY_P1_DOWN:  key_hit[0][JOY_DOWN]  = 1'b1;
      KEY_P1_LEFT:  key_hit[0][JOY_LEFT]  = 1'b1;
      KEY_P1_RIGHT: key_hit[0][JOY_RIGHT] = 1'b1;
      KEY_P1_BTN0:  key_hit[0][JOY_BTN0]  = 1'b1;
      KEY_P1_BTN1:  if (NUM_BUTTONS > 1) key_hit[0][JOY_BTN0+1] = 1'b1;
      KEY_P1_BTN2:  if (NUM_BUTTONS > 2) key_hit[0][JOY_BTN0+2] = 1'b1;
      KEY_P1_START: key_hit[0][JOY_STRT]  = 1'b1;
      KEY_P1_COIN:  key_hit[0][JOY_COIN]  = 1'b1;
      KEY_P1_PAUSE: key_hit[0][JOY_PAUS]  = 1'b1;
      KEY_P2_UP:    key_hit[1][JOY_UP]    = 1'b1;
      KEY_P2_DOWN:  key_hit[1][JOY_DOWN]  = 1'b1;
      KEY_P2_LEFT:  key_hit[1][JOY_LEFT]  = 1'b1;
      KEY_P2_RIGHT: key_hit[1][JOY_RIGHT] = 1'b1;
      KEY_P2_BTN0:  key_hit[1][JOY_BTN0]  = 1'b1;
      KEY_P2_BTN1:  if (NUM_BUTTONS > 1) key_hit[1][JOY_BTN0+1] = 1'b1;
      KEY_P2_BTN2:  if (NUM_BUTTONS > 2) key_hit[1][JOY_BTN0+2] = 1'b1;
      KEY_P2_START: key_hit[1][JOY_STRT]  = 1'b1;
      KEY_P2_COIN:  key_hit[1][JOY_COIN]  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q <= 1'b0;
      key_q    <= '0;
    end else begin
      strobe_q <= ps2_key[10];
      if (ps2_key[10] != strobe_q)
        key_q <= ps2_key[9] ? (key_q | key_hit) : (key_q & ~key_hit);
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [JW-1:0] raw;
    logic          ud_cancel;
    logic          lr_cancel;

    if (p < 2) begin : g_key
      assign raw = joystick[p] | key_q[p];
    end else begin : g_nokey
      assign raw = joystick[p];
    end

    assign ud_cancel  = socd_clean & raw[JOY_UP] & raw[JOY_DOWN];
    assign lr_cancel  = socd_clean & raw[JOY_LEFT] & raw[JOY_RIGHT];
    assign joy_d[p]   = {raw[JOY_UP] & ~ud_cancel, raw[JOY_DOWN] & ~ud_cancel,
                         raw[JOY_RIGHT] & ~lr_cancel, raw[JOY_LEFT] & ~lr_cancel};
    assign btn_d[p]   = raw[JOY_BTN0 +: NUM_BUTTONS] &
                        (~autofire_en[p] | {NUM_BUTTONS{phase_q}});
    assign start_d[p] = raw[JOY_STRT];
    assign raw_coin[p]  = raw[JOY_COIN];
    assign raw_pause[p] = raw[JOY_PAUS];

    tecmo_input_pulse #(.CYCLES(COIN_CYCLES)) u_coin (
      .clk     (clk),
      .reset_n (reset_n),
      .trig    (raw_coin[p]),
      .pulse   (coin[p])
    );
  end

  assign pause_any = |raw_pause;

  // Free-running autofire phase, plus registered player outputs and pause toggle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      af_cnt_q     <= '0;
      phase_q      <= 1'b0;
      pause_prev_q <= 1'b0;
      pause        <= 1'b0;
      joy          <= '0;
      buttons      <= '0;
      start        <= '0;
    end else begin
      if (af_cnt_q == AFW'(AUTOFIRE_DIV - 1)) begin
        af_cnt_q <= '0;
        phase_q  <= ~phase_q;
      end else begin
        af_cnt_q <= af_cnt_q + AFW'(1);
      end
      pause_prev_q <= pause_any;
      if (pause_any && !pause_prev_q) pause <= ~pause;
      joy     <= joy_d;
      buttons <= btn_d;
      start   <= start_d;
    end
  end

endmodule

// File: tb/tb_tecmo_input.sv
// Directed self-checking bench for tecmo_input (2 players, 3 buttons,
// autofire divider 4, coin pulse 10 cycles).
module tb_tecmo_input;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [10:0]      ps2_key;
  logic [1:0][9:0]  joystick;
  logic             socd_clean;
  logic [1:0][2:0]  autofire_en;
  logic [1:0][3:0]  joy;
  logic [1:0][2:0]  buttons;
  logic [1:0]       start;
  logic [1:0]       coin;
  logic             pause;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic strobe   = 1'b0;

  always #5 clk = ~clk;

  tecmo_input #(
    .NUM_PLAYERS(2), .NUM_BUTTONS(3), .AUTOFIRE_DIV(4), .COIN_CYCLES(10)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ps2_key(ps2_key), .joystick(joystick),
    .socd_clean(socd_clean), .autofire_en(autofire_en), .joy(joy),
    .buttons(buttons), .start(start), .coin(coin), .pause(pause)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic pressed, input logic [7:0] code);
    strobe  = ~strobe;
    ps2_key = {strobe, pressed, 1'b0, code};
  endtask

  task automatic do_reset;
    reset_n = 1'b0; joystick = '0; ps2_key = '0; strobe = 1'b0;
    socd_clean = 1'b0; autofire_en = '0;
    tick; tick;
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; joystick = '1; ps2_key = '0; strobe = 1'b0;
    socd_clean = 1'b0; autofire_en = '0;
    tick; tick;
    n_checks++; if (joy !== 8'h00) begin n_fail++; $display("FAIL rst_joy got %h want 00", joy); end
    n_checks++; if (buttons !== 6'h00) begin n_fail++; $display("FAIL rst_buttons got %h want 00", buttons); end
    n_checks++; if (start !== 2'b00) begin n_fail++; $display("FAIL rst_start got %b want 00", start); end
    n_checks++; if (coin !== 2'b00) begin n_fail++; $display("FAIL rst_coin got %b want 00", coin); end
    n_checks++; if (pause !== 1'b0) begin n_fail++; $display("FAIL rst_pause got %b want 0", pause); end
    reset_n = 1'b1;
    tick;
    n_checks++; if (joy !== 8'hFF) begin n_fail++; $display("FAIL rel_joy got %h want ff", joy); end
    n_checks++; if (buttons !== 6'h3F) begin n_fail++; $display("FAIL rel_buttons got %h want 3f", buttons); end
    n_checks++; if (start !== 2'b11) begin n_fail++; $display("FAIL rel_start got %b want 11", start); end
    n_checks++; if (coin !== 2'b11) begin n_fail++; $display("FAIL rel_coin got %b want 11", coin); end
    n_checks++; if (pause !== 1'b1) begin n_fail++; $display("FAIL rel_pause got %b want 1", pause); end
    do_reset;
    tick;
  endtask

  task automatic test_ps2;
    send_key(1'b1, 8'h75); tick;
    n_checks++; if (joy[0] !== 4'b0000) begin n_fail++; $display("FAIL ps2_up_lat1 got %b want 0000", joy[0]); end
    tick;
    n_checks++; if (joy[0] !== 4'b1000) begin n_fail++; $display("FAIL ps2_up_set got %b want 1000", joy[0]); end
    send_key(1'b0, 8'h75); tick;
    n_checks++; if (joy[0] !== 4'b1000) begin n_fail++; $display("FAIL ps2_up_hold got %b want 1000", joy[0]); end
    tick;
    n_checks++; if (joy[0] !== 4'b0000) begin n_fail++; $display("FAIL ps2_up_clr got %b want 0000", joy[0]); end
    send_key(1'b1, 8'h5A); tick; tick;
    n_checks++; if ({joy, buttons, start, pause} !== 17'h0) begin
      n_fail++; $display("FAIL ps2_unmapped got %h want 0", {joy, buttons, start, pause}); end
    send_key(1'b1, 8'h1C); tick; tick;
    n_checks++; if (buttons !== 6'b001000) begin n_fail++; $display("FAIL ps2_p2_btn0 got %b want 001000", buttons); end
    send_key(1'b0, 8'h1C); tick;
    send_key(1'b1, 8'h16); tick; tick;
    n_checks++; if ({start, buttons} !== 8'b01_000000) begin
      n_fail++; $display("FAIL ps2_p1_start got %b want 01000000", {start, buttons}); end
    send_key(1'b0, 8'h16); tick; tick;
    n_checks++; if (start !== 2'b00) begin n_fail++; $display("FAIL ps2_start_rel got %b want 00", start); end
    joystick[1][7] = 1'b1; tick;
    n_checks++; if (start !== 2'b10) begin n_fail++; $display("FAIL joy_start_lat got %b want 10", start); end
    joystick = '0; tick;
  endtask

  task automatic test_socd;
    socd_clean = 1'b1; joystick[0] = 10'h00C; tick;
    n_checks++; if (joy[0] !== 4'b0000) begin n_fail++; $display("FAIL socd_ud_on got %b want 0000", joy[0]); end
    socd_clean = 1'b0; tick;
    n_checks++; if (joy[0] !== 4'b1100) begin n_fail++; $display("FAIL socd_ud_off got %b want 1100", joy[0]); end
    socd_clean = 1'b1; joystick[0] = 10'h001; send_key(1'b1, 8'h6B); tick; tick;
    n_checks++; if (joy[0] !== 4'b0000) begin n_fail++; $display("FAIL socd_lr_mix got %b want 0000", joy[0]); end
    joystick[0] = 10'h009; tick;
    n_checks++; if (joy[0] !== 4'b1000) begin n_fail++; $display("FAIL socd_axis_indep got %b want 1000", joy[0]); end
    socd_clean = 1'b0; tick;
    n_checks++; if (joy[0] !== 4'b1011) begin n_fail++; $display("FAIL socd_off_mix got %b want 1011", joy[0]); end
    send_key(1'b0, 8'h6B); joystick = '0; tick; tick;
    n_checks++; if (joy !== 8'h00) begin n_fail++; $display("FAIL socd_release got %h want 00", joy); end
  endtask

  task automatic test_autofire;
    logic e;
    do_reset;
    autofire_en = 6'b000_001;
    joystick[0] = 10'h030;
    for (int n = 1; n <= 16; n++) begin
      tick;
      e = 1'(((n - 1) / 4) % 2);
      n_checks++;
      if (buttons[0] !== {1'b0, 1'b1, e}) begin
        n_fail++; $display("FAIL autofire cycle %0d got %b want %b", n, buttons[0], {1'b0, 1'b1, e}); end
    end
    joystick = '0; tick;
    n_checks++; if (buttons !== 6'h00) begin n_fail++; $display("FAIL autofire_release got %b want 000000", buttons); end
    autofire_en = '0;
  endtask

  task automatic test_coin;
    logic e;
    do_reset;
    joystick[0][8] = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      tick;
      e = (n <= 10);
      n_checks++;
      if (coin !== {1'b0, e}) begin n_fail++; $display("FAIL coin_hold cycle %0d got %b want %b", n, coin, {1'b0, e}); end
    end
    joystick = '0; tick; tick;
    for (int n = 1; n <= 15; n++) begin
      joystick[0][8] = (n == 1 || n == 2 || n == 5 || n == 6);
      tick;
      e = (n <= 10);
      n_checks++;
      if (coin !== {1'b0, e}) begin n_fail++; $display("FAIL coin_retrig cycle %0d got %b want %b", n, coin, {1'b0, e}); end
    end
    joystick = '0; tick;
    joystick[0][8] = 1'b1; tick; tick; tick;
    n_checks++; if (coin !== 2'b01) begin n_fail++; $display("FAIL coin_mid got %b want 01", coin); end
    reset_n = 1'b0; #1;
    n_checks++; if (coin !== 2'b00) begin n_fail++; $display("FAIL coin_async_rst got %b want 00", coin); end
    joystick = '0; tick;
    reset_n = 1'b1; tick;
  endtask

  task automatic test_pause;
    do_reset;
    tick;
    n_checks++; if (pause !== 1'b0) begin n_fail++; $display("FAIL pause_init got %b want 0", pause); end
    joystick[0][9] = 1'b1; joystick[1][9] = 1'b1; tick;
    n_checks++; if (pause !== 1'b1) begin n_fail++; $display("FAIL pause_both got %b want 1", pause); end
    tick; tick;
    n_checks++; if (pause !== 1'b1) begin n_fail++; $display("FAIL pause_held got %b want 1", pause); end
    joystick = '0; tick;
    n_checks++; if (pause !== 1'b1) begin n_fail++; $display("FAIL pause_released got %b want 1", pause); end
    joystick[0][9] = 1'b1; tick;
    n_checks++; if (pause !== 1'b0) begin n_fail++; $display("FAIL pause_p1_again got %b want 0", pause); end
    joystick[1][9] = 1'b1; tick;
    n_checks++; if (pause !== 1'b0) begin n_fail++; $display("FAIL pause_overlap got %b want 0", pause); end
    joystick = '0; tick;
    send_key(1'b1, 8'h4D); tick;
    n_checks++; if (pause !== 1'b0) begin n_fail++; $display("FAIL pause_key_lat got %b want 0", pause); end
    tick;
    n_checks++; if (pause !== 1'b1) begin n_fail++; $display("FAIL pause_key got %b want 1", pause); end
    send_key(1'b0, 8'h4D); tick; tick;
    n_checks++; if (pause !== 1'b1) begin n_fail++; $display("FAIL pause_key_rel got %b want 1", pause); end
  endtask

  initial begin
    test_reset;
    test_ps2;
    test_socd;
    test_autofire;
    test_coin;
    test_pause;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
